// File: rtl/module_button_pkg.sv
// Shared constants for the push-button conditioning path.
// Synthesis uses the default debounce window; simulation uses the short one.
package module_button_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 10_000_000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;
  localparam int SYNC_STAGES             = 2;

endpackage

// File: rtl/module_debounce_channel.sv
// One button channel: synchroniser, stability counter, stable level register
// and single-cycle press/release pulses generated alongside the level update.
module module_debounce_channel
  import module_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   synced_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_nxt_s;
  logic                   press_nxt_s;
  logic                   release_nxt_s;

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    cnt_nxt_s     = CNT_ZERO;
    level_nxt_s   = level;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    if (synced_s == level) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r != CNT_LAST) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s     = CNT_ZERO;
      level_nxt_s   = synced_s;
      press_nxt_s   = synced_s;
      release_nxt_s = ~synced_s;
    end
  end

  // State registers; reset discards any in-flight count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r        <= {SYNC_STAGES{1'b0}};
      cnt_r         <= CNT_ZERO;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_r        <= {sync_r[SYNC_STAGES-2:0], button_raw};
      cnt_r         <= cnt_nxt_s;
      level         <= level_nxt_s;
      press         <= press_nxt_s;
      release_pulse <= release_nxt_s;
    end
  end

endmodule

// File: rtl/module_button_debouncer.sv
// Debounces N_BUTTONS independent push buttons into clean levels for
// module_leds plus one-cycle press/release pulses.
module module_button_debouncer
  import module_button_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] button_raw_i,
  output logic [N_BUTTONS-1:0] push_button_o,
  output logic [N_BUTTONS-1:0] press_o,
  output logic [N_BUTTONS-1:0] release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    module_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .button_raw    (button_raw_i[i]),
      .level         (push_button_o[i]),
      .press         (press_o[i]),
      .release_pulse (release_o[i])
    );
  end

endmodule

// File: tb/tb_module_button_debouncer.sv
// Directed bench for module_button_debouncer with a 4-cycle debounce window.
// Edge e is the e-th rising edge after the raw pattern was applied.
module tb_module_button_debouncer;
  import module_button_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] button_raw_i;
  logic [3:0] push_button_o;
  logic [3:0] press_o;
  logic [3:0] release_o;

  int checks   = 0;
  int failures = 0;

  module_button_debouncer #(
    .N_BUTTONS       (4),
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_raw_i  (button_raw_i),
    .push_button_o (push_button_o),
    .press_o       (press_o),
    .release_o     (release_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_push,
                           input logic [3:0] e_press, input logic [3:0] e_rel);
    check({tag, "_push"}, push_button_o, e_push);
    check({tag, "_press"}, press_o, e_press);
    check({tag, "_release"}, release_o, e_rel);
  endtask

  initial begin
    rst_n        = 1'b0;
    button_raw_i = 4'b0000;
    for (int e = 1; e <= 3; e++) tick();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;

    // Clean press on bit 0: reported at edge 6 only.
    button_raw_i = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_all("clean_press", (e >= 6) ? 4'b0001 : 4'b0000,
                (e == 6) ? 4'b0001 : 4'b0000, 4'b0000);
    end
    // Clean release of bit 0.
    button_raw_i = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_all("clean_release", (e >= 6) ? 4'b0000 : 4'b0001,
                4'b0000, (e == 6) ? 4'b0001 : 4'b0000);
    end

    // Bit 2 high for 3 cycles: rejected.
    button_raw_i = 4'b0100;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) button_raw_i = 4'b0000;
      tick();
      check_all("glitch3", 4'b0000, 4'b0000, 4'b0000);
    end
    // Bit 2 high for exactly 4 cycles: accepted, then released.
    button_raw_i = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      if (e == 5) button_raw_i = 4'b0000;
      tick();
      check_all("glitch4", (e >= 6 && e < 10) ? 4'b0100 : 4'b0000,
                (e == 6) ? 4'b0100 : 4'b0000, (e == 10) ? 4'b0100 : 4'b0000);
    end

    // Chatter on bit 1 (1,0,1,0 then held 1): one press at edge 10.
    for (int e = 1; e <= 13; e++) begin
      button_raw_i = (e == 2 || e == 4) ? 4'b0000 : 4'b0010;
      tick();
      check_all("chatter", (e >= 10) ? 4'b0010 : 4'b0000,
                (e == 10) ? 4'b0010 : 4'b0000, 4'b0000);
    end
    button_raw_i = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_all("chatter_rel", (e >= 6) ? 4'b0000 : 4'b0010,
                4'b0000, (e == 6) ? 4'b0010 : 4'b0000);
    end

    // Bits 0 and 2 together, then bit 0 released while bit 2 held.
    button_raw_i = 4'b0101;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_all("dual_press", (e >= 6) ? 4'b0101 : 4'b0000,
                (e == 6) ? 4'b0101 : 4'b0000, 4'b0000);
    end
    button_raw_i = 4'b0100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_all("dual_rel0", (e >= 6) ? 4'b0100 : 4'b0101,
                4'b0000, (e == 6) ? 4'b0001 : 4'b0000);
    end
    button_raw_i = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_all("dual_rel2", (e >= 6) ? 4'b0000 : 4'b0100,
                4'b0000, (e == 6) ? 4'b0100 : 4'b0000);
    end

    // Reset at edge 4 while bit 3 is counting; full latency restarts at edge 5.
    button_raw_i = 4'b1000;
    for (int e = 1; e <= 12; e++) begin
      rst_n = (e == 4) ? 1'b0 : 1'b1;
      tick();
      check_all("rst_mid", (e >= 10) ? 4'b1000 : 4'b0000,
                (e == 10) ? 4'b1000 : 4'b0000, 4'b0000);
    end
    // Reset while bit 3 is reported: output clears, then re-debounces.
    for (int e = 1; e <= 8; e++) begin
      rst_n = (e == 1) ? 1'b0 : 1'b1;
      tick();
      check_all("rst_held", (e == 1 || e >= 7) ? ((e == 1) ? 4'b0000 : 4'b1000) : 4'b0000,
                (e == 7) ? 4'b1000 : 4'b0000, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
